memory_digit_reader: RTL
========================

// Module: memory_digit_reader
// PURPOSE
//   Reads back a calculator operand, operator or result one 4-bit digit at a time, MSB first.
//   Output uses a valid/ready stream to the display/print path.
//   Inverse of the memory write path, which builds each value by shift-left-4 plus digit.
//   Sits between the operand memory/ALU and the display driver.
// PARAMETERS
//   NDIG   4   digits per word; word width W = 4*NDIG
//   IDXW   2   dig_idx width; localparam = $clog2(NDIG)
// PORTS
//   clk          in   1     system clock, rising edge
//   rst_n        in   1     asynchronous, active-low reset
//   save1        in   W     operand 1 from memory
//   save2        in   W     operand 2 from memory
//   res          in   W     ALU result
//   op_out       in   4     stored operator code
//   src          in   2     00=res 01=save1 10={W-4 zeros,op_out} 11=save2
//   start        in   1     request readout of src (sampled in IDLE only)
//   clear_enable in   1     synchronous abort, same meaning as memory clear
//   dig_ready    in   1     downstream accepts digit
//   dig_data     out  4     current digit
//   dig_valid    out  1     dig_data valid
//   dig_last     out  1     current digit is final digit of word
//   dig_idx      out  IDXW  digit position, 0 = most significant
//   busy         out  1     readout in progress (state != IDLE)
//   done         out  1     one-cycle pulse after last handshake
// BEHAVIOUR
//   - rst_n low (async): state IDLE; shadow, counter and all outputs 0 immediately.
//   - States: IDLE -> SEND -> DONE -> IDLE.
//   - IDLE: start=1 and clear_enable=0 -> capture selected word into shadow reg.
//     Set dig_idx=0 and state SEND. dig_valid=1 from the next cycle (latency 1).
//   - SEND: dig_data = shadow[W-1:W-4].
//     dig_valid & dig_ready -> shadow <<= 4, dig_idx += 1.
//   - dig_last = dig_valid & (dig_idx == NDIG-1).
//     A handshake with dig_last=1 -> DONE; dig_valid=0 in DONE.
//   - Backpressure: while dig_valid & !dig_ready, dig_data/dig_idx/dig_last hold stable. No timeout.
//   - DONE: done=1 for exactly one cycle, then IDLE.
//   - Throughput with dig_ready=1: NDIG digits on NDIG consecutive cycles.
//   - start outside IDLE (SEND, DONE) is ignored; it is not queued.
//   - src and source words are sampled only at capture. Later changes to save1/save2/res do not affect a transfer.
//   - clear_enable=1 in any state -> next edge: IDLE, shadow=0, dig_valid=0, no done pulse.
//     Has priority over start and over a simultaneous handshake.
//   - Unused bits: op_out is zero-extended. No arithmetic; digits are raw nibbles, 0xA-0xF passed unchanged.
// CONFIGURATION
//   LZB_EN defined (leading-zero blanking):
//     - At capture, skip leading zero nibbles; shadow is pre-shifted.
//     - dig_idx starts at the first nonzero digit's true position.
//     - An all-zero word emits a single digit 0 with dig_idx=NDIG-1 and dig_last=1.
//     - Capture-to-first-valid latency is still 1 cycle (combinational priority encode at capture).
//   LZB_EN undefined: always exactly NDIG digits, dig_idx starts at 0.
// TESTING
//   1. src=01, save1=16'h1234, start, ready=1 -> digits 1,2,3,4 on 4 consecutive cycles.
//      idx 0..3, last on 4, done one cycle after.
//   2. Same as 1, ready=0 for 3 cycles while digit 2 valid -> dig_data=2, idx=1 held stable.
//      Then 3,4 follow; no digit lost or duplicated.
//   3. src=10, op_out=4'h3 -> 0,0,0,3.
//      With LZB_EN: single digit 3, idx=3, last=1.
//   4. src=11, save2=16'hABCD; change save2 and pulse start during SEND -> stream remains A,B,C,D.
//      Second start ignored, single done.
//   5. clear_enable during digit 2 -> dig_valid=0 next cycle, busy=0, no done.
//      rst_n low mid-transfer -> all outputs 0 without a clock edge.
//   6. LZB_EN, src=00, res=16'h0000 -> one digit 0 with last=1, done next cycle.
//      Without LZB_EN: four zeros.

Source files
------------

// File: rtl/memory_digit_reader_if.sv
// Digit stream from the memory readback path to the display/print path.
interface memory_digit_reader_if #(
  parameter int unsigned NDIG = 4
) ();
  localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [3:0]      dig_data;
  logic            dig_valid;
  logic            dig_last;
  logic [IDXW-1:0] dig_idx;
  logic            dig_ready;

  modport master (output dig_data, dig_valid, dig_last, dig_idx, input dig_ready);
  modport slave  (input dig_data, dig_valid, dig_last, dig_idx, output dig_ready);
endinterface

// File: rtl/memory_digit_reader.sv
// Reads an operand, operator or result back one nibble at a time, MSB first.
// Optional leading-zero blanking is enabled by defining LZB_EN.
module memory_digit_reader #(
  parameter int unsigned NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*NDIG-1:0]     save1,
  input  logic [4*NDIG-1:0]     save2,
  input  logic [4*NDIG-1:0]     res,
  input  logic [3:0]            op_out,
  input  logic [1:0]            src,
  input  logic                  start,
  input  logic                  clear_enable,
  memory_digit_reader_if.master dig,
  output logic                  busy,
  output logic                  done
);
  localparam int unsigned W    = 4 * NDIG;
  localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t          state;
  logic [W-1:0]    shadow;
  logic            valid_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    sel_word;
  logic [W-1:0]    cap_word;
  logic [IDXW-1:0] cap_idx;
  logic            last_c;

  // Source select; the operator code is zero-extended to a full word.
  always_comb begin
    sel_word = '0;
    unique case (src)
      2'b00: sel_word = res;
      2'b01: sel_word = save1;
      2'b10: sel_word = {{(W-4){1'b0}}, op_out};
      2'b11: sel_word = save2;
      default: sel_word = '0;
    endcase
  end

`ifdef LZB_EN
  logic found;

  // Count leading zero nibbles, capped so an all-zero word still emits its last digit.
  always_comb begin
    cap_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(NDIG) - 1; i++) begin
      if (!found && sel_word[W-1-4*i -: 4] == 4'h0) cap_idx = IDXW'(i + 1);
      else                                          found   = 1'b1;
    end
    cap_word = sel_word << {cap_idx, 2'b00};
  end
`else
  always_comb begin
    cap_idx  = '0;
    cap_word = sel_word;
  end
`endif

  assign last_c        = valid_q && (idx_q == IDXW'(NDIG - 1));
  assign dig.dig_data  = shadow[W-1 -: 4];
  assign dig.dig_valid = valid_q;
  assign dig.dig_last  = last_c;
  assign dig.dig_idx   = idx_q;

  // Readout FSM; clear_enable overrides start and any handshake in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shadow  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (clear_enable) begin
      state   <= IDLE;
      shadow  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shadow  <= cap_word;
            idx_q   <= cap_idx;
            valid_q <= 1'b1;
            busy    <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (valid_q && dig.dig_ready) begin
            if (last_c) begin
              shadow  <= '0;
              idx_q   <= '0;
              valid_q <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              shadow <= {shadow[W-5:0], 4'h0};
              idx_q  <= idx_q + IDXW'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end
endmodule
